// File: rtl/fifo_rd_packer_pkg.sv
// Shared defaults and FSM encoding for the FIFO read-side packer.
package fifo_rd_packer_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int PACK_DEF   = 2;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_EMIT  = 2'd2
   } pack_state_t;

endpackage

// File: rtl/fifo_rd_packer_out_reg.sv
// One-word valid/ready holding register for packed words.
// A load is only issued when can_load is high, so a held word is never overwritten.
module pack_out_reg #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic              load_partial,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_partial,
   output logic              accept,
   output logic              can_load
);

   assign accept   = out_valid & out_ready;
   assign can_load = !out_valid | out_ready;

   // holding register: load takes priority, accept empties it, data held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_partial <= 1'b0;
      end else if (load) begin
         out_data    <= load_data;
         out_valid   <= 1'b1;
         out_partial <= load_partial;
      end else if (accept) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops entries, packs PACK of them per output word,
// and emits a zero-padded partial word on flush.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | normal packing, pops allowed
//   ST_DRAIN | flush seen: no new pops, wait for the in-flight entry
//   ST_EMIT  | push the partial word into the out register when it frees
module fifo_rd_packer
   import fifo_rd_packer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PACK   = PACK_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     rd_clk,
   input  logic                     rd_rst,
   input  logic                     fifo_empty,
   input  logic [DATA_W-1:0]        fifo_data_out,
   output logic                     fifo_rd_en,
   input  logic                     flush,
   output logic [DATA_W*PACK-1:0]   out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_partial,
   output logic                     flush_done,
   output logic [CNT_W-1:0]         word_cnt
);

   localparam int WORD_W = DATA_W * PACK;
   localparam int FILL_W = $clog2(PACK + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PACK);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PACK - 1);
   localparam logic [FILL_W:0]   PACK_EXT  = (FILL_W + 1)'(PACK);

   pack_state_t         state_q, state_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic                pending_q;
   logic [WORD_W-1:0]   asm_q, asm_d, asm_word;
   logic                word_full, word_move, emit_load, load;
   logic                accept, can_load;
   logic                done_raw;
   logic [FILL_W:0]     occupancy;

   // assembly as it stands after this cycle's capture (unused slots stay zero)
   always_comb begin
      asm_word = asm_q;
      if (pending_q && (fill_q < FILL_FULL))
         asm_word[int'(fill_q)*DATA_W +: DATA_W] = fifo_data_out;
   end

   // A word completing this cycle moves straight to the out register when it is
   // free, and the pop for the next word may issue in that same cycle; this is
   // what sustains one entry per clock.
   assign word_full = pending_q ? (fill_q == FILL_LAST) : (fill_q == FILL_FULL);
   assign word_move = word_full & can_load;
   assign load      = word_move | emit_load;
   assign occupancy = {1'b0, fill_q} + (FILL_W + 1)'(pending_q);

   assign fifo_rd_en = !rd_rst && !fifo_empty && (state_q == ST_RUN) && !flush &&
                       ((occupancy < PACK_EXT) || word_move);

   assign flush_done = done_raw & !rd_rst;

   // flush FSM next-state and strobes
   always_comb begin
      state_d   = state_q;
      emit_load = 1'b0;
      done_raw  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (flush) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!pending_q) begin
               if (fill_q == '0) begin
                  done_raw = 1'b1;
                  state_d  = ST_RUN;
               end else if (fill_q != FILL_FULL) begin
                  state_d  = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (can_load) begin
               emit_load = 1'b1;
               done_raw  = 1'b1;
               state_d   = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // next fill level and assembly contents
   always_comb begin
      fill_d = fill_q;
      asm_d  = asm_word;
      if (load) begin
         fill_d = '0;
         asm_d  = '0;
      end else if (pending_q) begin
         fill_d = fill_q + FILL_W'(1);
      end
   end

   // state, assembly and in-flight pop tracking
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q   <= ST_RUN;
         fill_q    <= '0;
         pending_q <= 1'b0;
         asm_q     <= '0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         pending_q <= fifo_rd_en;
         asm_q     <= asm_d;
      end
   end

   // accepted-word counter, wraps naturally
   always_ff @(posedge rd_clk) begin
      if (rd_rst)      word_cnt <= '0;
      else if (accept) word_cnt <= word_cnt + CNT_W'(1);
   end

   pack_out_reg #(.WORD_W(WORD_W)) u_out_reg (
      .clk          (rd_clk),
      .rst          (rd_rst),
      .load         (load),
      .load_data    (asm_word),
      .load_partial (emit_load),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_partial  (out_partial),
      .accept       (accept),
      .can_load     (can_load)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO read port.
module tb_fifo_rd_packer;

   logic        rd_clk = 1'b0;
   logic        rd_rst = 1'b1;
   logic        fifo_empty;
   logic [3:0]  fifo_data_out = '0;
   logic        fifo_rd_en;
   logic        flush = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_partial;
   logic        flush_done;
   logic [15:0] word_cnt;

   logic        w_rd_en, w_valid, w_partial, w_done;
   logic [7:0]  w_data;
   logic [3:0]  w_cnt;

   int total = 0;
   int bad   = 0;

   logic [3:0] stim [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic hide = 1'b0;
   logic alt  = 1'b0;

   logic [7:0] rec_data [256];
   logic       rec_part [256];
   int n_rec  = 0;
   int n_fd   = 0;
   int viol   = 0;
   int w_diff = 0;

   always #5 rd_clk = ~rd_clk;

   assign fifo_empty = (rd_ptr == wr_ptr) || hide;

   fifo_rd_packer #(.DATA_W(4), .PACK(2), .CNT_W(16)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_partial(out_partial), .flush_done(flush_done), .word_cnt(word_cnt)
   );

   fifo_rd_packer #(.DATA_W(4), .PACK(2), .CNT_W(4)) dut_w (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_rd_en(w_rd_en), .flush(flush),
      .out_data(w_data), .out_valid(w_valid), .out_ready(out_ready),
      .out_partial(w_partial), .flush_done(w_done), .word_cnt(w_cnt)
   );

   // FIFO read port: one-cycle read latency
   always @(posedge rd_clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_data_out <= stim[rd_ptr];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   // output monitor, sampled mid-cycle
   always @(negedge rd_clk) begin
      if (out_valid && out_ready) begin
         rec_data[n_rec] = out_data;
         rec_part[n_rec] = out_partial;
         n_rec++;
      end
      if (flush_done) n_fd++;
      if (fifo_rd_en && fifo_empty) viol++;
      if (w_data !== out_data || w_valid !== out_valid || w_rd_en !== fifo_rd_en ||
          w_partial !== out_partial || w_done !== flush_done) w_diff++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge rd_clk);
      #2;
      if (alt) hide = ~hide;
   endtask

   task automatic push(input logic [3:0] v);
      stim[wr_ptr] = v;
      wr_ptr++;
   endtask

   task automatic wait_words(input string tag, input int target, input int budget, output int used);
      used = 0;
      while (n_rec < target && used < budget) begin
         step();
         used++;
      end
      chk({tag, "_timeout"}, 32'(n_rec >= target), 32'd1);
   endtask

   task automatic do_reset();
      rd_rst = 1'b1;
      step();
      step();
      rd_rst = 1'b0;
   endtask

   initial begin
      int base, used, fd0, pops0;
      logic [7:0] exp_w;

      // reset state
      step();
      step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_cnt", 32'(word_cnt), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      rd_rst = 1'b0;
      step();

      // T1: basic packing
      out_ready = 1'b1;
      base = n_rec;
      push(4'd0); push(4'd11); push(4'd6); push(4'd5);
      wait_words("t1", base + 2, 30, used);
      chk("t1_w0", 32'(rec_data[base]), 32'hB0);
      chk("t1_w1", 32'(rec_data[base+1]), 32'h56);
      chk("t1_p0", 32'(rec_part[base]), 32'd0);
      chk("t1_p1", 32'(rec_part[base+1]), 32'd0);
      chk("t1_cnt", 32'(word_cnt), 32'd2);

      // T2: backpressure, two words buffered
      out_ready = 1'b0;
      base = n_rec;
      pops0 = rd_ptr;
      for (int i = 1; i <= 8; i++) push(4'(i));
      for (int i = 0; i < 20; i++) step();
      chk("t2_pops", 32'(rd_ptr - pops0), 32'd4);
      chk("t2_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_hold0", 32'(out_data), 32'h21);
      for (int i = 0; i < 5; i++) step();
      chk("t2_hold1", 32'(out_data), 32'h21);
      chk("t2_pops_hold", 32'(rd_ptr - pops0), 32'd4);
      out_ready = 1'b1;
      wait_words("t2", base + 4, 40, used);
      chk("t2_w0", 32'(rec_data[base]), 32'h21);
      chk("t2_w1", 32'(rec_data[base+1]), 32'h43);
      chk("t2_w2", 32'(rec_data[base+2]), 32'h65);
      chk("t2_w3", 32'(rec_data[base+3]), 32'h87);
      chk("t2_cnt", 32'(word_cnt), 32'd6);

      // T3: flush of a partial word, then a no-op flush
      base = n_rec;
      push(4'd9);
      for (int i = 0; i < 8; i++) step();
      chk("t3_held", 32'(out_valid), 32'd0);
      fd0 = n_fd;
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_words("t3", base + 1, 20, used);
      for (int i = 0; i < 4; i++) step();
      chk("t3_word", 32'(rec_data[base]), 32'h09);
      chk("t3_partial", 32'(rec_part[base]), 32'd1);
      chk("t3_done_once", 32'(n_fd - fd0), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("t3_noop_done", 32'(n_fd - fd0), 32'd2);
      chk("t3_noop_words", 32'(n_rec - base), 32'd1);
      chk("t3_cnt", 32'(word_cnt), 32'd7);

      // T4: reset with one slot filled and a pop in flight
      push(4'd10);
      for (int i = 0; i < 5; i++) step();
      push(4'd12);
      step();
      chk("t4_inflight", 32'(rd_ptr), 32'(wr_ptr));
      rd_rst = 1'b1;
      step();
      chk("t4_valid", 32'(out_valid), 32'd0);
      chk("t4_data", 32'(out_data), 32'h0);
      chk("t4_partial", 32'(out_partial), 32'd0);
      chk("t4_done", 32'(flush_done), 32'd0);
      chk("t4_cnt", 32'(word_cnt), 32'd0);
      chk("t4_rd_en", 32'(fifo_rd_en), 32'd0);
      rd_rst = 1'b0;
      base = n_rec;
      push(4'd3); push(4'd13);
      wait_words("t4", base + 1, 20, used);
      chk("t4_word", 32'(rec_data[base]), 32'hD3);

      // T5: FIFO empty every other cycle
      do_reset();
      base = n_rec;
      alt = 1'b1;
      for (int i = 0; i < 22; i++) push(4'(i % 16));
      wait_words("t5", base + 11, 120, used);
      alt  = 1'b0;
      hide = 1'b0;
      for (int j = 0; j < 11; j++) begin
         exp_w = {4'((2 * j + 1) % 16), 4'((2 * j) % 16)};
         chk($sformatf("t5_w%0d", j), 32'(rec_data[base+j]), 32'(exp_w));
      end
      chk("t5_cnt", 32'(word_cnt), 32'd11);

      // T6: counter wrap at 4 bits, full-rate stream
      do_reset();
      base = n_rec;
      for (int i = 0; i < 34; i++) push(4'(i % 16));
      wait_words("t6", base + 17, 60, used);
      chk("t6_rate", 32'(used <= 40), 32'd1);
      chk("t6_cnt16", 32'(word_cnt), 32'd17);
      chk("t6_cnt4", 32'(w_cnt), 32'd1);

      chk("no_pop_when_empty", 32'(viol), 32'd0);
      chk("instances_agree", 32'(w_diff), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
